// File: rtl/otter_pipe_pkg.sv
// otter_pipe_pkg: shared types and constants for the pipelined OTTER.
//   fetch_entry_t  : {pc, instr} pair carried from fetch to decode.
//   OTTER_NOP      : canonical NOP encoding (addi x0, x0, 0).
//   OTTER_RESET_PC : default program counter after reset.
package otter_pipe_pkg;

  localparam logic [31:0] OTTER_NOP      = 32'h0000_0013;
  localparam logic [31:0] OTTER_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bus bundle between the fetch stage and its neighbours.
//   MEM_*      : instruction memory read port 1 (1-cycle synchronous read).
//   REDIRECT*  : taken branch/jump from execute.
//   DE_READY / IF_VALID / INSTR / IF_PC / IF_PC_PLUS4 : decode handshake.
//   STAT_*     : fetch statistics, present only with FETCH_STATS_EN.
// master = fetch stage side, slave = memory/execute/decode side.
interface fetch_stage_if;

  logic [31:0] MEM_ADDR1;
  logic        MEM_RDEN1;
  logic [31:0] MEM_RAW_DOUT1;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        DE_READY;
  logic        IF_VALID;
  logic [31:0] INSTR;
  logic [31:0] IF_PC;
  logic [31:0] IF_PC_PLUS4;
`ifdef FETCH_STATS_EN
  logic [31:0] STAT_FETCHED;
  logic [31:0] STAT_FLUSHED;
`endif

  modport master (
    output MEM_ADDR1, MEM_RDEN1, IF_VALID, INSTR, IF_PC, IF_PC_PLUS4,
`ifdef FETCH_STATS_EN
    output STAT_FETCHED, STAT_FLUSHED,
`endif
    input  MEM_RAW_DOUT1, REDIRECT, REDIRECT_PC, DE_READY
  );

  modport slave (
    input  MEM_ADDR1, MEM_RDEN1, IF_VALID, INSTR, IF_PC, IF_PC_PLUS4,
`ifdef FETCH_STATS_EN
    input  STAT_FETCHED, STAT_FLUSHED,
`endif
    output MEM_RAW_DOUT1, REDIRECT, REDIRECT_PC, DE_READY
  );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of fetch_entry_t, QDEPTH entries.
//   clk_i, rst_ni : clock, asynchronous active-low reset.
//   flush_i       : synchronous clear; wins over push.
//   push_i/push_data_i, pop_i : enqueue / dequeue head.
//   head_o        : registered head entry; holds its last value while empty.
//   count_o       : number of stored entries, 0..QDEPTH.
module fetch_queue
  import otter_pipe_pkg::*;
#(
  parameter int unsigned QDEPTH = 2,
  localparam int unsigned CW    = $clog2(QDEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  fetch_entry_t  mem_q [QDEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  fetch_entry_t  head_q, head_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = ptr_inc(wr_q);
      if (pop_i)  rd_d = ptr_inc(rd_q);
      unique case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      // Head is a register so it can hold across empty periods; when the
      // new head slot is the one being written now, bypass the push data.
      if (cnt_d != '0) begin
        head_d = (push_i && (rd_d == wr_q)) ? push_data_i : mem_q[rd_d];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: OTTER instruction fetch stage.
//   IF_CLK, IF_RST_N : clock, asynchronous active-low reset.
//   bus (fetch_stage_if.master): memory read port 1, redirect from execute,
//   valid/ready handshake of {INSTR, IF_PC, IF_PC_PLUS4} to decode.
// Issues one read per cycle while the queue has credit for the returning
// word; REDIRECT flushes queue and in-flight read and refetches the target.
// Optional macro FETCH_STATS_EN adds saturating STAT_FETCHED/STAT_FLUSHED.
module fetch_stage
  import otter_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = OTTER_RESET_PC,
  parameter int unsigned QDEPTH   = 2
) (
  input logic           IF_CLK,
  input logic           IF_RST_N,
  fetch_stage_if.master bus
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned OW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic          pend_v_q, pend_v_d;
  logic [CW-1:0] count;
  fetch_entry_t  head, push_entry;
  logic          pop, push, issue;
  logic [OW-1:0] occupancy;
  logic [31:0]   redirect_addr;

  always_comb begin
    redirect_addr = bus.REDIRECT_PC & 32'hFFFF_FFFC;
    pop           = (count != '0) & bus.DE_READY & !bus.REDIRECT;
    push          = pend_v_q & !bus.REDIRECT;
    push_entry    = '{pc: pend_pc_q, instr: bus.MEM_RAW_DOUT1};
    // Entries held plus the word in flight, minus the one leaving now.
    occupancy     = {1'b0, count} + OW'(pend_v_q) - OW'(pop);
    issue         = IF_RST_N & !bus.REDIRECT & (occupancy < OW'(QDEPTH));

    bus.MEM_ADDR1 = fetch_pc_q;
    bus.MEM_RDEN1 = issue;
    fetch_pc_d    = fetch_pc_q;
    pend_pc_d     = pend_pc_q;
    pend_v_d      = 1'b0;
    if (IF_RST_N && bus.REDIRECT) begin
      bus.MEM_ADDR1 = redirect_addr;
      bus.MEM_RDEN1 = 1'b1;
      pend_v_d      = 1'b1;
      pend_pc_d     = redirect_addr;
      fetch_pc_d    = redirect_addr + 32'd4;
    end else if (issue) begin
      pend_v_d      = 1'b1;
      pend_pc_d     = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge IF_CLK or negedge IF_RST_N) begin
    if (!IF_RST_N) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      pend_v_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_v_q   <= pend_v_d;
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk_i       (IF_CLK),
    .rst_ni      (IF_RST_N),
    .flush_i     (bus.REDIRECT),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus.IF_VALID    = (count != '0);
  assign bus.INSTR       = head.instr;
  assign bus.IF_PC       = head.pc;
  assign bus.IF_PC_PLUS4 = head.pc + 32'd4;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_flushed_q;
  logic [32:0] flushed_sum;

  assign flushed_sum = {1'b0, stat_flushed_q} + 33'(count) + 33'(pend_v_q);

  always_ff @(posedge IF_CLK or negedge IF_RST_N) begin
    if (!IF_RST_N) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      if (pop && (stat_fetched_q != '1)) stat_fetched_q <= stat_fetched_q + 32'd1;
      if (bus.REDIRECT) stat_flushed_q <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end

  assign bus.STAT_FETCHED = stat_fetched_q;
  assign bus.STAT_FLUSHED = stat_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import otter_pipe_pkg::*;

  localparam int unsigned QD  = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .IF_CLK   (clk),
    .IF_RST_N (rst_n),
    .bus      (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a;
  endfunction

  // Memory with one-cycle synchronous read.
  always @(posedge clk) begin
    if (bus.MEM_RDEN1) bus.MEM_RAW_DOUT1 <= mem_word(bus.MEM_ADDR1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pcs waiting for decode, the read in flight, next fetch pc.
  logic [31:0] mq[$];
  logic        m_pv;
  logic [31:0] m_ppc, m_fpc, m_last_pc, m_last_instr;
  logic [31:0] m_fetched, m_flushed;

  task automatic model_reset();
    mq.delete();
    m_pv = 1'b0; m_ppc = '0; m_fpc = RPC;
    m_last_pc = '0; m_last_instr = '0;
    m_fetched = '0; m_flushed = '0;
  endtask

  task automatic check_reset_values();
    check("rst_valid", {31'b0, bus.IF_VALID}, 32'd0);
    check("rst_rden",  {31'b0, bus.MEM_RDEN1}, 32'd0);
    check("rst_addr",  bus.MEM_ADDR1, RPC);
    check("rst_instr", bus.INSTR, 32'd0);
    check("rst_pc",    bus.IF_PC, 32'd0);
    check("rst_pc4",   bus.IF_PC_PLUS4, 32'd4);
`ifdef FETCH_STATS_EN
    check("rst_stat_fetched", bus.STAT_FETCHED, 32'd0);
    check("rst_stat_flushed", bus.STAT_FLUSHED, 32'd0);
`endif
  endtask

  // Called at a negedge: drive inputs, compare outputs, advance model.
  task automatic cycle(input logic redir, input logic [31:0] rpc, input logic rdy);
    logic        exp_valid, pop, issue;
    logic [31:0] exp_pc, exp_instr, tgt;
    longint      occ, fl;
    bus.REDIRECT    = redir;
    bus.REDIRECT_PC = rpc;
    bus.DE_READY    = rdy;
    #1;
    exp_valid = (mq.size() != 0);
    exp_pc    = exp_valid ? mq[0] : m_last_pc;
    exp_instr = exp_valid ? mem_word(mq[0]) : m_last_instr;
    pop       = exp_valid && rdy && !redir;
    tgt       = {rpc[31:2], 2'b00};
    occ       = longint'(mq.size()) + longint'(m_pv) - longint'(pop);
    issue     = redir || (occ < longint'(QD));

    check("if_valid", {31'b0, bus.IF_VALID}, {31'b0, exp_valid});
    check("if_pc",    bus.IF_PC, exp_pc);
    check("instr",    bus.INSTR, exp_instr);
    check("pc_plus4", bus.IF_PC_PLUS4, exp_pc + 32'd4);
    check("rden",     {31'b0, bus.MEM_RDEN1}, {31'b0, issue});
    if (issue) check("addr", bus.MEM_ADDR1, redir ? tgt : m_fpc);
`ifdef FETCH_STATS_EN
    check("stat_fetched", bus.STAT_FETCHED, m_fetched);
    check("stat_flushed", bus.STAT_FLUSHED, m_flushed);
`endif

    m_last_pc    = exp_pc;
    m_last_instr = exp_instr;
    if (redir) begin
      fl = longint'(m_flushed) + longint'(mq.size()) + longint'(m_pv);
      m_flushed = (fl > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : fl[31:0];
      mq.delete();
      m_pv  = 1'b1;
      m_ppc = tgt;
      m_fpc = tgt + 32'd4;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        if (m_fetched != 32'hFFFF_FFFF) m_fetched = m_fetched + 32'd1;
      end
      if (m_pv) mq.push_back(m_ppc);
      if (issue) begin
        m_ppc = m_fpc;
        m_fpc = m_fpc + 32'd4;
        m_pv  = 1'b1;
      end else begin
        m_pv  = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, rdy);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.REDIRECT    = 1'b0;
    bus.REDIRECT_PC = '0;
    bus.DE_READY    = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // Free run, then stall with full queue, then resume.
    run(20, 1'b1);
    run(5, 1'b0);
    run(8, 1'b1);

    // Redirect with full queue and a word in flight.
    run(4, 1'b0);
    cycle(1'b1, 32'h0000_0103, 1'b0);
    run(6, 1'b1);

    // Redirect coinciding with a ready head.
    cycle(1'b1, 32'h0000_0200, 1'b1);
    run(6, 1'b1);

    // Address wrap.
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
    run(6, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic [31:0] t;
      r = ($urandom_range(0, 15) == 0);
      t = $urandom;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      cycle(r, t, ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    bus.REDIRECT = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(12, 1'b1);
    for (int i = 0; i < 500; i++)
      cycle(($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 1) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
